// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction fetch queue between instruction memory and decode. Owns the
//   fetch PC and prefetches sequential instructions into a DEPTH-entry
//   circular buffer. It absorbs instruction-memory wait-states and decode
//   stalls. A redirect from EX flushes every queued entry and restarts fetch
//   at the word-aligned target.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   imem_addr    fetch address (the fetch PC register)
//   imem_inst    instruction at imem_addr, same cycle
//   imem_valid   imem_inst valid this cycle (0 = wait-state)
//   redirect     taken branch/jump from EX
//   redirect_pc  redirect target; the low two bits are dropped
//   deq_ready    decode accepts the head entry
//   deq_valid    head entry valid (never asserted during a redirect)
//   deq_inst     head instruction, NOP when deq_valid = 0
//   deq_pc       head PC, 0 when deq_valid = 0
//   count        occupied entries, 0..DEPTH
//   full/empty   count == DEPTH / count == 0
module fetch_queue #(
  parameter int unsigned          XLEN     = 32,
  parameter int unsigned          DEPTH    = 4,
  parameter logic [XLEN-1:0]      RESET_PC = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic [XLEN-1:0]         imem_addr,
  input  logic [31:0]             imem_inst,
  input  logic                    imem_valid,
  input  logic                    redirect,
  input  logic [XLEN-1:0]         redirect_pc,
  input  logic                    deq_ready,
  output logic                    deq_valid,
  output logic [31:0]             deq_inst,
  output logic [XLEN-1:0]         deq_pc,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [XLEN-1:0] fpc;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];

  logic enq;
  logic deq;
  logic unused_low;

  assign unused_low = ^redirect_pc[1:0];

  assign imem_addr = fpc;
  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));

  // The wrong-path head must not reach decode in the redirect cycle.
  assign deq_valid = ~empty & ~redirect;
  assign deq       = deq_valid & deq_ready;
  // A full queue still accepts a new entry when the head leaves this cycle.
  assign enq       = imem_valid & ~redirect & (~full | deq);

  assign deq_inst  = deq_valid ? inst_mem[rd_ptr] : NOP;
  assign deq_pc    = deq_valid ? pc_mem[rd_ptr]   : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fpc    <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (redirect) begin
      fpc    <= {redirect_pc[XLEN-1:2], 2'b00};
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (enq) begin
        fpc    <= fpc + XLEN'(4);
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (deq) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({enq, deq})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is never cleared; validity lives only in cnt and the pointers.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[wr_ptr]   <= fpc;
      inst_mem[wr_ptr] <= imem_inst;
    end
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch queue that replaces the fixed single-entry fetch register between instruction memory and decode in the 5-stage RV32I pipeline. It owns the fetch PC, prefetches sequential instructions into a DEPTH-entry circular buffer, and tolerates instruction-memory wait-states. Decode stalls are absorbed without stalling fetch until the queue is full. A taken branch or jump from EX flushes all wrong-path entries and restarts fetch at the target.

## Interface
Parameters:
- XLEN, 32, width of PC and address paths
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- imem_addr  out  XLEN  fetch address to instruction memory; equals fetch PC register
- imem_inst  in  32  instruction at imem_addr, same cycle
- imem_valid  in  1  imem_inst valid this cycle; 0 = wait-state
- redirect  in  1  taken branch/jump from EX (br_taken)
- redirect_pc  in  XLEN  target address (ALUResultM)
- deq_ready  in  1  decode accepts head entry (~StallD)
- deq_valid  out  1  head entry valid
- deq_inst  out  32  head instruction; 32'h0000_0013 (NOP) when deq_valid=0
- deq_pc  out  XLEN  head PC; 0 when deq_valid=0
- count  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- State: fpc (fetch PC), storage of DEPTH entries {pc, inst}, wr_ptr/rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count.
- deq = deq_valid & deq_ready & ~redirect.
- enq = imem_valid & ~redirect & (~full | deq). Enqueue into a full queue is legal when a dequeue occurs in the same cycle.
- On enq: write {fpc, imem_inst} at wr_ptr; wr_ptr+1; fpc <= fpc + 4 (modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0).
- On deq: rd_ptr+1.
- count next = count + enq − deq; simultaneous enq and deq leaves count unchanged.
- deq_valid = ~empty & ~redirect. Wrong-path head is never handed to decode in the redirect cycle.
- Redirect has highest priority:
  - count, wr_ptr and rd_ptr are set to 0.
  - fpc <= {redirect_pc[XLEN-1:2], 2'b00}; misaligned low bits are dropped.
  - No enq and no deq occur in that cycle, regardless of imem_valid or deq_ready.
- imem_valid=0 with queue not full: fpc holds and no entry is written.
- Full with no deq: fpc holds and imem_inst is ignored. The same address is refetched next cycle.
- Entry storage is not cleared on flush; validity is tracked only by count and the pointers.

## Timing
- Reset (rst=0, async): fpc=RESET_PC, pointers=0, count=0, deq_valid=0, deq_inst=NOP, deq_pc=0, empty=1, full=0, imem_addr=RESET_PC. Reset deassertion is taken synchronously by the surrounding logic. The first fetch occurs at the first rising edge with rst=1.
- Fetch-to-decode latency: an instruction enqueued at edge N is presented with deq_valid=1 in the cycle after edge N. There is no same-cycle bypass.
- Throughput: 1 instruction/cycle sustained when imem_valid=1 and deq_ready=1.
- Redirect asserted in cycle R:
  - Cycle R+1: imem_addr=target, deq_valid=0.
  - The target instruction is presented in cycle R+2 if imem_valid=1 in R+1.
- deq_inst and deq_pc are driven combinationally from the storage registers addressed by rd_ptr. deq_valid, full, empty and count depend on registered state plus redirect only.
- Reset asserted mid-operation discards all entries immediately. Outputs take their reset values without waiting for a clock edge.

## Test plan
- Reset then free run, DEPTH=4, imem_valid=1, deq_ready=1 -> deq_pc sequence 0,4,8,12 from cycle 2 onward; count steady at 1.
- deq_ready=0 for 6 cycles -> count 1,2,3,4,4,4; full=1; imem_addr frozen at 0x10; on release, deq_pc 0x0,0x4,0x8,0xC,0x10 with no gaps or duplicates.
- Full queue, deq_ready=1, imem_valid=1 in the same cycle -> count stays 4; new entry PC 0x10 is enqueued and the head advances.
- redirect=1, redirect_pc=0x103 with count=3 -> that cycle deq_valid=0; next cycle count=0, imem_addr=0x100, deq_inst=NOP; cycle after, deq_pc=0x100.
- imem_valid toggled 1,0,0,1 -> only two entries written, PCs 0x0 and 0x4; fpc holds during the wait-states.
- RESET_PC=32'hFFFF_FFF8, free run -> deq_pc FFFF_FFF8, FFFF_FFFC, 0000_0000; asynchronous rst pulse mid-stream -> count=0 and deq_valid=0 with no clock edge required.
